// File: rtl/ext_mode_driver_pkg.sv
// Shared types for the matrix multiplier external (memory-bypass) mode driver.
// The struct widths follow the multiplier's default 4x4, 8-bit configuration.
package ext_mode_driver_pkg;

    localparam int EXT_WIDTH = 8;
    localparam int EXT_ROW   = 4;
    localparam int EXT_COL   = 4;

    typedef struct packed {
        logic [EXT_COL*EXT_WIDTH-1:0] ext_weight;
        logic                         ext_weight_en;
        logic [EXT_ROW*EXT_WIDTH-1:0] ext_input;
        logic                         ext_valid;
    } external_inputs_struct;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        FILL   = 3'd2,
        BURST  = 3'd3,
        WAIT   = 3'd4,
        OUT    = 3'd5
    } drv_state_e;

endpackage

// File: rtl/ext_vec_buffer.sv
// Register file holding the input vectors of one job so the burst can be
// replayed without gaps. Write is clocked, read is combinational.
module ext_vec_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 2
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_reg [DEPTH];

    // Contents need no reset: every entry is rewritten before each burst.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (we && (waddr == AW'(gi))) begin
                mem_reg[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/ext_mode_driver.sv
// Host-side initiator for the multiplier's external mode: loads weights, buffers
// ROW input vectors, replays them as one gapless burst and returns the result row.
// Optional result timeout: define EXT_MODE_DRIVER_TIMEOUT_EN.
module ext_mode_driver
    import ext_mode_driver_pkg::*;
#(
    parameter int WIDTH   = EXT_WIDTH,
    parameter int ROW     = EXT_ROW,
    parameter int COL     = EXT_COL,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   job_valid_i,
    input  logic                   job_reload_w_i,
    output logic                   job_ready_o,
    input  logic                   w_valid_i,
    input  logic [COL*WIDTH-1:0]   w_data_i,
    output logic                   w_ready_o,
    input  logic                   x_valid_i,
    input  logic [ROW*WIDTH-1:0]   x_data_i,
    output logic                   x_ready_o,
    output logic                   res_valid_o,
    output logic [COL*WIDTH-1:0]   res_data_o,
    input  logic                   res_ready_i,
    output logic                   ext_en_o,
    output external_inputs_struct  ext_inputs_o,
    input  logic [COL*WIDTH-1:0]   ext_result_i,
    input  logic                   ext_valid_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int CNT_W = $clog2(ROW + 1);
    localparam int AW    = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW - 1);

    drv_state_e             state_reg, state_next;
    logic [CNT_W-1:0]       wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0]       rd_cnt_reg, rd_cnt_next;
    logic                   ext_en_reg;
    logic                   res_valid_reg, res_valid_next;
    logic [COL*WIDTH-1:0]   res_data_reg, res_data_next;
    logic [ROW*WIDTH-1:0]   buf_rdata;
    logic                   w_fire, x_fire, res_capture, to_expire;

    assign w_fire = (state_reg == LOAD_W) && w_valid_i;
    assign x_fire = (state_reg == FILL) && x_valid_i;
    // A multiplier that answers one cycle early is still caught on the last burst cycle.
    assign res_capture = ext_valid_i &&
                         ((state_reg == WAIT) || ((state_reg == BURST) && (rd_cnt_reg == LAST)));

`ifdef EXT_MODE_DRIVER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;

    assign to_expire = (state_reg == WAIT) && !ext_valid_i && (to_cnt_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            to_cnt_reg <= (state_reg == WAIT) ? to_cnt_reg + TO_W'(1) : '0;
            if (to_expire) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_o = err_reg;
`else
    assign to_expire = 1'b0;
    // Always 0; TIMEOUT only matters when the timeout is enabled.
    assign err_o = (TIMEOUT < 0);
`endif

    ext_vec_buffer #(
        .DEPTH (ROW),
        .DW    (ROW*WIDTH),
        .AW    (AW)
    ) u_buf (
        .clk_i (clk_i),
        .we    (x_fire),
        .waddr (wr_cnt_reg[AW-1:0]),
        .wdata (x_data_i),
        .raddr (rd_cnt_reg[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        res_valid_next = res_valid_reg;
        res_data_next  = res_data_reg;
        case (state_reg)
            IDLE: begin
                if (job_valid_i) begin
                    state_next  = job_reload_w_i ? LOAD_W : FILL;
                    wr_cnt_next = '0;
                    rd_cnt_next = '0;
                end
            end
            LOAD_W: begin
                if (w_fire) begin
                    wr_cnt_next = (wr_cnt_reg == LAST) ? '0 : wr_cnt_reg + CNT_W'(1);
                    if (wr_cnt_reg == LAST) state_next = FILL;
                end
            end
            FILL: begin
                if (x_fire) begin
                    wr_cnt_next = (wr_cnt_reg == LAST) ? '0 : wr_cnt_reg + CNT_W'(1);
                    if (wr_cnt_reg == LAST) state_next = BURST;
                end
            end
            BURST: begin
                rd_cnt_next = (rd_cnt_reg == LAST) ? '0 : rd_cnt_reg + CNT_W'(1);
                if (rd_cnt_reg == LAST) state_next = WAIT;
            end
            WAIT: ;
            OUT: begin
                if (res_ready_i) begin
                    state_next     = IDLE;
                    res_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (res_capture) begin
            state_next     = OUT;
            res_valid_next = 1'b1;
            res_data_next  = ext_result_i;
        end
        if (to_expire) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= IDLE;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            ext_en_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            ext_en_reg    <= (state_next != IDLE);
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
        end
    end

    // Weight and input fields are zeroed outside their active beats.
    always_comb begin
        ext_inputs_o               = '0;
        ext_inputs_o.ext_weight_en = w_fire;
        ext_inputs_o.ext_valid     = (state_reg == BURST);
        if (w_fire) ext_inputs_o.ext_weight = w_data_i;
        if (state_reg == BURST) ext_inputs_o.ext_input = buf_rdata;
    end

    assign job_ready_o = (state_reg == IDLE) && rstn_i;
    assign w_ready_o   = (state_reg == LOAD_W);
    assign x_ready_o   = (state_reg == FILL);
    assign busy_o      = (state_reg != IDLE);
    assign ext_en_o    = ext_en_reg;
    assign res_valid_o = res_valid_reg;
    assign res_data_o  = res_data_reg;

endmodule

// File: tb/tb_ext_mode_driver.sv
// Randomized bench for ext_mode_driver with a behavioural multiplier model and
// transaction logs compared against the jobs the host sent.
module tb_ext_mode_driver;
    import ext_mode_driver_pkg::*;

    localparam int WIDTH = 8;
    localparam int ROW   = 4;
    localparam int COL   = 4;
`ifdef EXT_MODE_DRIVER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic                  clk;
    logic                  rstn_i;
    logic                  job_valid_i, job_reload_w_i, job_ready_o;
    logic                  w_valid_i, w_ready_o;
    logic [COL*WIDTH-1:0]  w_data_i;
    logic                  x_valid_i, x_ready_o;
    logic [ROW*WIDTH-1:0]  x_data_i;
    logic                  res_valid_o, res_ready_i;
    logic [COL*WIDTH-1:0]  res_data_o;
    logic                  ext_en_o;
    external_inputs_struct ext_inputs_o;
    logic [COL*WIDTH-1:0]  ext_result_i;
    logic                  ext_valid_i;
    logic                  busy_o, err_o;

    int checks   = 0;
    int failures = 0;

    // Multiplier model state and transaction logs (written only by the model process)
    logic [31:0] wlog[$];
    logic [31:0] xlog[$];
    int          runs[$];
    int          run_cur = 0;
    bit          pending = 0;
    bit          mult_enable = 0;
    bit          inject_spurious = 0;
    logic [31:0] mult_result = '0;

    logic [31:0] w_vals [ROW];
    logic [31:0] x_vals [ROW];
    logic        en_before, en_after;

    ext_mode_driver #(
        .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .job_valid_i(job_valid_i), .job_reload_w_i(job_reload_w_i), .job_ready_o(job_ready_o),
        .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
        .x_valid_i(x_valid_i), .x_data_i(x_data_i), .x_ready_o(x_ready_o),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i),
        .ext_en_o(ext_en_o), .ext_inputs_o(ext_inputs_o),
        .ext_result_i(ext_result_i), .ext_valid_i(ext_valid_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier: after ROW contiguous ext_valid cycles it answers once, in the next cycle.
    always @(negedge clk) begin
        if (!rstn_i) begin
            run_cur     = 0;
            pending     = 0;
            ext_valid_i = 1'b0;
        end else begin
            if (ext_inputs_o.ext_weight_en) wlog.push_back(ext_inputs_o.ext_weight);
            if (ext_inputs_o.ext_valid) begin
                xlog.push_back(ext_inputs_o.ext_input);
                run_cur++;
            end else if (run_cur != 0) begin
                runs.push_back(run_cur);
                run_cur = 0;
            end
            ext_valid_i  = pending | inject_spurious;
            ext_result_i = pending ? mult_result : $urandom();
            pending      = ext_inputs_o.ext_valid && (run_cur == ROW) && mult_enable;
        end
    end

    task automatic send_job(input bit reload);
        int n = 0;
        job_reload_w_i = reload;
        job_valid_i    = 1'b1;
        @(negedge clk);
        while (!job_ready_o && n < 50) begin @(negedge clk); n++; end
        if (!job_ready_o) begin
            checks++; failures++;
            $display("FAIL job_accept: job_ready_o=%0b required=1", job_ready_o);
        end
        en_before = ext_en_o;
        @(posedge clk); #1;
        job_valid_i = 1'b0;
        en_after    = ext_en_o;
    endtask

    task automatic send_w(input logic [31:0] d, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        w_valid_i = 1'b1; w_data_i = d;
        @(negedge clk);
        while (!w_ready_o && n < 50) begin @(negedge clk); n++; end
        if (!w_ready_o) begin
            checks++; failures++;
            $display("FAIL w_accept: w_ready_o=%0b required=1", w_ready_o);
        end
        @(posedge clk); #1;
        w_valid_i = 1'b0; w_data_i = $urandom();
    endtask

    task automatic send_x(input logic [31:0] d, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        x_valid_i = 1'b1; x_data_i = d;
        @(negedge clk);
        while (!x_ready_o && n < 50) begin @(negedge clk); n++; end
        if (!x_ready_o) begin
            checks++; failures++;
            $display("FAIL x_accept: x_ready_o=%0b required=1", x_ready_o);
        end
        @(posedge clk); #1;
        x_valid_i = 1'b0; x_data_i = $urandom();
    endtask

    task automatic wait_result(output bit got);
        int n = 0;
        @(negedge clk);
        while (!res_valid_o && n < 60) begin @(negedge clk); n++; end
        got = res_valid_o;
    endtask

    task automatic release_result();
        @(posedge clk); #1; res_ready_i = 1'b1;
        @(posedge clk); #1; res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({job_ready_o, w_ready_o, x_ready_o, res_valid_o, busy_o, ext_en_o, err_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got=%b required=0000000",
                     {job_ready_o, w_ready_o, x_ready_o, res_valid_o, busy_o, ext_en_o, err_o});
        end
        checks++;
        if (ext_inputs_o !== '0 || res_data_o !== '0) begin
            failures++;
            $display("FAIL reset_data: ext_inputs=%h res_data=%h required=0", ext_inputs_o, res_data_o);
        end
        @(posedge clk); #1; rstn_i = 1'b1;
        @(negedge clk);
        checks++;
        if (job_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: job_ready=%b busy=%b required=1,0", job_ready_o, busy_o);
        end
        $display("txn reset: released, job_ready=%b", job_ready_o);
        @(posedge clk); #1;
    endtask

    task automatic test_reload_job();
        int wb = wlog.size();
        int xb = xlog.size();
        int rb = runs.size();
        bit got;
        for (int i = 0; i < ROW; i++) begin
            w_vals[i] = 32'(i + 1);
            x_vals[i] = $urandom();
        end
        mult_result = 32'h0A0B0C0D;
        mult_enable = 1'b1;
        send_job(1'b1);
        checks++;
        if (en_before !== 1'b0 || en_after !== 1'b1) begin
            failures++;
            $display("FAIL ext_en_rise: before=%b after=%b required=0,1", en_before, en_after);
        end
        checks++;
        if (busy_o !== 1'b1 || job_ready_o !== 1'b0 || w_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL load_w_entry: busy=%b job_ready=%b w_ready=%b required=1,0,1", busy_o, job_ready_o, w_ready_o);
        end
        for (int i = 0; i < ROW; i++) send_w(w_vals[i], 1 + $urandom_range(2));
        checks++;
        if (x_ready_o !== 1'b1 || w_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fill_entry: x_ready=%b w_ready=%b required=1,0", x_ready_o, w_ready_o);
        end
        for (int i = 0; i < ROW; i++) send_x(x_vals[i], 1 + $urandom_range(2));
        wait_result(got);
        checks++;
        if (!got || res_data_o !== 32'h0A0B0C0D) begin
            failures++;
            $display("FAIL reload_result: valid=%b data=%h required=1,0a0b0c0d", got, res_data_o);
        end
        checks++;
        if (wlog.size() - wb != ROW) begin
            failures++;
            $display("FAIL weight_pulses: got=%0d required=%0d", wlog.size() - wb, ROW);
        end
        for (int i = 0; i < ROW; i++) begin
            checks++;
            if (wlog[wb + i] !== w_vals[i]) begin
                failures++;
                $display("FAIL weight_row%0d: got=%h required=%h", i, wlog[wb + i], w_vals[i]);
            end
        end
        checks++;
        if (runs.size() - rb != 1 || runs[rb] != ROW) begin
            failures++;
            $display("FAIL burst_shape: runs=%0d first_len=%0d required=1,%0d", runs.size() - rb, runs[rb], ROW);
        end
        for (int i = 0; i < ROW; i++) begin
            checks++;
            if (xlog[xb + i] !== x_vals[i]) begin
                failures++;
                $display("FAIL burst_vec%0d: got=%h required=%h", i, xlog[xb + i], x_vals[i]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid_o !== 1'b1 || res_data_o !== 32'h0A0B0C0D) begin
                failures++;
                $display("FAIL result_hold%0d: valid=%b data=%h required=1,0a0b0c0d", c, res_valid_o, res_data_o);
            end
        end
        release_result();
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || job_ready_o !== 1'b1 || ext_en_o !== 1'b0) begin
            failures++;
            $display("FAIL result_release: valid=%b busy=%b job_ready=%b ext_en=%b required=0,0,1,0",
                     res_valid_o, busy_o, job_ready_o, ext_en_o);
        end
        $display("txn reload_job: result=%h", 32'h0A0B0C0D);
    endtask

    task automatic run_plain_job(input bit reload, input bit spurious, input int hold, input string tag);
        int wb = wlog.size();
        int xb = xlog.size();
        int rb = runs.size();
        int exp_w = reload ? ROW : 0;
        bit got;
        for (int i = 0; i < ROW; i++) begin
            w_vals[i] = $urandom();
            x_vals[i] = $urandom();
        end
        mult_result = $urandom();
        mult_enable = 1'b1;
        send_job(reload);
        if (reload) for (int i = 0; i < ROW; i++) send_w(w_vals[i], $urandom_range(2));
        for (int i = 0; i < ROW - 1; i++) send_x(x_vals[i], $urandom_range(2));
        inject_spurious = spurious;
        send_x(x_vals[ROW-1], 1 + $urandom_range(1));
        inject_spurious = 1'b0;
        wait_result(got);
        checks++;
        if (!got || res_data_o !== mult_result) begin
            failures++;
            $display("FAIL %s_result: valid=%b data=%h required=1,%h", tag, got, res_data_o, mult_result);
        end
        checks++;
        if (wlog.size() - wb != exp_w) begin
            failures++;
            $display("FAIL %s_weight_pulses: got=%0d required=%0d", tag, wlog.size() - wb, exp_w);
        end
        for (int i = 0; i < exp_w; i++) begin
            checks++;
            if (wlog[wb + i] !== w_vals[i]) begin
                failures++;
                $display("FAIL %s_weight%0d: got=%h required=%h", tag, i, wlog[wb + i], w_vals[i]);
            end
        end
        checks++;
        if (runs.size() - rb != 1 || runs[rb] != ROW) begin
            failures++;
            $display("FAIL %s_burst_shape: runs=%0d first_len=%0d required=1,%0d", tag, runs.size() - rb, runs[rb], ROW);
        end
        for (int i = 0; i < ROW; i++) begin
            checks++;
            if (xlog[xb + i] !== x_vals[i]) begin
                failures++;
                $display("FAIL %s_vec%0d: got=%h required=%h", tag, i, xlog[xb + i], x_vals[i]);
            end
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid_o !== 1'b1 || res_data_o !== mult_result) begin
                failures++;
                $display("FAIL %s_hold%0d: valid=%b data=%h required=1,%h", tag, c, res_valid_o, res_data_o, mult_result);
            end
        end
        release_result();
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: valid=%b busy=%b required=0,0", tag, res_valid_o, busy_o);
        end
        $display("txn %s: reload=%0b spurious=%0b hold=%0d result=%h", tag, reload, spurious, hold, mult_result);
    endtask

    task automatic test_no_reload();
        run_plain_job(1'b0, 1'b0, 0, "no_reload");
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            run_plain_job(1'($urandom_range(1)), 1'b1, $urandom_range(3), "random_job");
        end
    endtask

    task automatic test_reset_mid_burst();
        int rb = runs.size();
        bit saw_valid = 0;
        for (int i = 0; i < ROW; i++) x_vals[i] = $urandom();
        mult_result = $urandom();
        mult_enable = 1'b1;
        send_job(1'b0);
        for (int i = 0; i < ROW; i++) send_x(x_vals[i], $urandom_range(1));
        @(posedge clk); #1;
        checks++;
        if (ext_inputs_o.ext_valid !== 1'b1) begin
            failures++;
            $display("FAIL burst_cycle2: ext_valid=%b required=1", ext_inputs_o.ext_valid);
        end
        rstn_i = 1'b0;
        #1;
        checks++;
        if (ext_inputs_o.ext_valid !== 1'b0 || ext_en_o !== 1'b0 || busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_burst_reset: ext_valid=%b ext_en=%b busy=%b res_valid=%b required=0,0,0,0",
                     ext_inputs_o.ext_valid, ext_en_o, busy_o, res_valid_o);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rstn_i = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (res_valid_o) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || runs.size() != rb || job_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL no_partial_result: res_valid_seen=%b new_runs=%0d job_ready=%b required=0,0,1",
                     saw_valid, runs.size() - rb, job_ready_o);
        end
        $display("txn reset_mid_burst: job aborted in burst cycle 2");
        @(posedge clk); #1;
    endtask

`ifdef EXT_MODE_DRIVER_TIMEOUT_EN
    task automatic test_timeout();
        for (int i = 0; i < ROW; i++) x_vals[i] = $urandom();
        mult_enable = 1'b0;
        send_job(1'b0);
        for (int i = 0; i < ROW; i++) send_x(x_vals[i], 0);
        // Now in burst cycle 1: ROW burst cycles, then the 8th wait cycle.
        repeat (ROW + TB_TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_before: busy=%b err=%b required=1,0", busy_o, err_o);
        end
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || res_valid_o !== 1'b0 || job_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort: err=%b busy=%b res_valid=%b job_ready=%b required=1,0,0,1",
                     err_o, busy_o, res_valid_o, job_ready_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || res_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: err=%b res_valid=%b required=1,0", err_o, res_valid_o);
        end
        @(posedge clk); #1; rstn_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err=%b required=0", err_o);
        end
        @(posedge clk); #1; rstn_i = 1'b1;
        $display("txn timeout: err raised after %0d wait cycles", TB_TIMEOUT);
    endtask
`else
    task automatic test_wait_forever();
        bit bad = 0;
        for (int i = 0; i < ROW; i++) x_vals[i] = $urandom();
        mult_enable = 1'b0;
        send_job(1'b0);
        for (int i = 0; i < ROW; i++) send_x(x_vals[i], 0);
        repeat (100) begin
            @(negedge clk);
            if (busy_o !== 1'b1 || res_valid_o !== 1'b0 || err_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wait_forever: busy=%b res_valid=%b err=%b required=1,0,0", busy_o, res_valid_o, err_o);
        end
        @(posedge clk); #1; rstn_i = 1'b0;
        @(posedge clk); #1; rstn_i = 1'b1;
        $display("txn wait_forever: still waiting after 100 cycles, err=%b", err_o);
    endtask
`endif

    initial begin
        rstn_i = 1'b0;
        job_valid_i = 1'b0; job_reload_w_i = 1'b0;
        w_valid_i = 1'b0; w_data_i = '0;
        x_valid_i = 1'b0; x_data_i = '0;
        res_ready_i = 1'b0;
        test_reset();
        test_reload_job();
        test_no_reload();
        test_random_jobs();
        test_reset_mid_burst();
`ifdef EXT_MODE_DRIVER_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
